ptp_pdelay_resp: RTL and testbench

- Responder side of the 802.1AS peer-delay exchange; the counterpart of the requester path-delay computation.
- Latches each parsed Pdelay_Req: sequenceId, requesting portIdentity, ingress receipt timestamp.
- Issues a Pdelay_Resp transmit request, waits for the MAC egress timestamp of that Resp, then issues a Pdelay_Resp_Follow_Up carrying it.
- Sits between the PTP RX parser / RX timestamp unit and the PTP TX frame builder.

---
 rtl/ptp_pdelay_resp.sv | 192 +++++++++++++++++++
 tb/tb_ptp_pdelay_resp.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ptp_pdelay_resp.sv
// 802.1AS peer-delay responder: answers each Pdelay_Req with a Pdelay_Resp and then a Follow_Up
// that carries the Resp egress timestamp. Optional one-entry request buffer: PDELAY_RESP_PENDING_BUF_EN.
module ptp_pdelay_resp #(
   parameter int unsigned TS_TIMEOUT_CYC = 250000,
   parameter int unsigned TO_CNT_W       = 18
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_valid,
   input  logic [15:0] i_req_seqid,
   input  logic [79:0] i_req_port_id,
   input  logic [79:0] i_req_rx_ts,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic [3:0]  o_tx_msg_type,
   output logic [15:0] o_tx_seqid,
   output logic [79:0] o_tx_req_port_id,
   output logic [79:0] o_tx_timestamp,
   input  logic [79:0] i_egress_ts,
   input  logic        i_egress_ts_valid,
   output logic        o_busy,
   output logic        o_ts_timeout,
   output logic [15:0] o_drop_cnt
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] SEND_RESP = 2'd1;
   localparam logic [1:0] WAIT_TS   = 2'd2;
   localparam logic [1:0] SEND_FUP  = 2'd3;

   localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TS_TIMEOUT_CYC - 1);

   logic [1:0]          state_q, state_d;
   logic [15:0]         seqid_q, seqid_d;
   logic [79:0]         port_q, port_d;
   logic [79:0]         rx_ts_q, rx_ts_d;
   logic [79:0]         eg_ts_q, eg_ts_d;
   logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
   logic [15:0]         drop_q, drop_d;
   logic                timeout_q, timeout_d;
   logic                busy_req, fup_done, to_hit;

`ifdef PDELAY_RESP_PENDING_BUF_EN
   logic                pend_vld_q, pend_vld_d;
   logic [15:0]         pend_seqid_q, pend_seqid_d;
   logic [79:0]         pend_port_q, pend_port_d;
   logic [79:0]         pend_ts_q, pend_ts_d;
`endif

   assign busy_req = i_req_valid && (state_q != IDLE);
   assign fup_done = (state_q == SEND_FUP) && i_tx_ready;
   // A timestamp arriving on the final count still wins over the timeout.
   assign to_hit   = (state_q == WAIT_TS) && !i_egress_ts_valid && (to_cnt_q == TO_LAST);

   always_comb begin
      state_d   = state_q;
      seqid_d   = seqid_q;
      port_d    = port_q;
      rx_ts_d   = rx_ts_q;
      eg_ts_d   = eg_ts_q;
      to_cnt_d  = to_cnt_q;
      drop_d    = drop_q;
      timeout_d = 1'b0;
`ifdef PDELAY_RESP_PENDING_BUF_EN
      pend_vld_d   = pend_vld_q;
      pend_seqid_d = pend_seqid_q;
      pend_port_d  = pend_port_q;
      pend_ts_d    = pend_ts_q;
`endif

      case (state_q)
         IDLE: begin
            if (i_req_valid) begin
               seqid_d = i_req_seqid;
               port_d  = i_req_port_id;
               rx_ts_d = i_req_rx_ts;
               state_d = SEND_RESP;
            end
         end
         SEND_RESP: begin
            if (i_tx_ready) begin
               to_cnt_d = '0;
               state_d  = WAIT_TS;
            end
         end
         WAIT_TS: begin
            if (i_egress_ts_valid) begin
               eg_ts_d = i_egress_ts;
               state_d = SEND_FUP;
            end else if (to_hit) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               to_cnt_d = to_cnt_q + TO_CNT_W'(1);
            end
         end
         SEND_FUP: begin
            if (i_tx_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef PDELAY_RESP_PENDING_BUF_EN
      // On the way back to IDLE a waiting request (buffered, or arriving right now) starts the next exchange.
      if (fup_done || to_hit) begin
         if (pend_vld_q) begin
            seqid_d = pend_seqid_q;
            port_d  = pend_port_q;
            rx_ts_d = pend_ts_q;
            state_d = SEND_RESP;
            if (i_req_valid) begin
               pend_seqid_d = i_req_seqid;
               pend_port_d  = i_req_port_id;
               pend_ts_d    = i_req_rx_ts;
            end else begin
               pend_vld_d = 1'b0;
            end
         end else if (i_req_valid) begin
            seqid_d = i_req_seqid;
            port_d  = i_req_port_id;
            rx_ts_d = i_req_rx_ts;
            state_d = SEND_RESP;
         end
      end else if (busy_req) begin
         pend_vld_d   = 1'b1;
         pend_seqid_d = i_req_seqid;
         pend_port_d  = i_req_port_id;
         pend_ts_d    = i_req_rx_ts;
         if (pend_vld_q && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
         end
      end
`else
      if (busy_req && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end
`endif
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         seqid_q   <= '0;
         port_q    <= '0;
         rx_ts_q   <= '0;
         eg_ts_q   <= '0;
         to_cnt_q  <= '0;
         drop_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         seqid_q   <= seqid_d;
         port_q    <= port_d;
         rx_ts_q   <= rx_ts_d;
         eg_ts_q   <= eg_ts_d;
         to_cnt_q  <= to_cnt_d;
         drop_q    <= drop_d;
         timeout_q <= timeout_d;
      end
   end

`ifdef PDELAY_RESP_PENDING_BUF_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pend_vld_q   <= 1'b0;
         pend_seqid_q <= '0;
         pend_port_q  <= '0;
         pend_ts_q    <= '0;
      end else begin
         pend_vld_q   <= pend_vld_d;
         pend_seqid_q <= pend_seqid_d;
         pend_port_q  <= pend_port_d;
         pend_ts_q    <= pend_ts_d;
      end
   end
`endif

   // Transmit fields are decoded from registered state only, so they cannot change while valid waits for ready.
   assign o_tx_valid       = (state_q == SEND_RESP) || (state_q == SEND_FUP);
   assign o_tx_msg_type    = (state_q == SEND_RESP) ? 4'h3 :
                             (state_q == SEND_FUP)  ? 4'hA : 4'h0;
   assign o_tx_seqid       = o_tx_valid ? seqid_q : 16'h0;
   assign o_tx_req_port_id = o_tx_valid ? port_q : 80'h0;
   assign o_tx_timestamp   = (state_q == SEND_RESP) ? rx_ts_q :
                             (state_q == SEND_FUP)  ? eg_ts_q : 80'h0;
   assign o_busy           = (state_q != IDLE);
   assign o_ts_timeout     = timeout_q;
   assign o_drop_cnt       = drop_q;

endmodule

// File: tb/tb_ptp_pdelay_resp.sv
// Directed bench for ptp_pdelay_resp: cycle table for the nominal exchange plus hand-written
// sequences for backpressure, timeout, drop-while-busy and reset mid-exchange.
module tb_ptp_pdelay_resp;

   localparam int TO_CYC = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        reqValid = 1'b0;
   logic [15:0] reqSeqid = '0;
   logic [79:0] reqPortId = '0;
   logic [79:0] reqRxTs = '0;
   logic        txValid;
   logic        txReady = 1'b0;
   logic [3:0]  txMsgType;
   logic [15:0] txSeqid;
   logic [79:0] txReqPortId;
   logic [79:0] txTimestamp;
   logic [79:0] egressTs = '0;
   logic        egressTsValid = 1'b0;
   logic        busy;
   logic        tsTimeout;
   logic [15:0] dropCnt;

   int passCnt = 0;
   int totalCnt = 0;

   always #5 clk = ~clk;

   ptp_pdelay_resp #(.TS_TIMEOUT_CYC(TO_CYC), .TO_CNT_W(18)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(reqValid), .i_req_seqid(reqSeqid), .i_req_port_id(reqPortId), .i_req_rx_ts(reqRxTs),
      .o_tx_valid(txValid), .i_tx_ready(txReady), .o_tx_msg_type(txMsgType), .o_tx_seqid(txSeqid),
      .o_tx_req_port_id(txReqPortId), .o_tx_timestamp(txTimestamp),
      .i_egress_ts(egressTs), .i_egress_ts_valid(egressTsValid),
      .o_busy(busy), .o_ts_timeout(tsTimeout), .o_drop_cnt(dropCnt)
   );

   typedef struct {
      logic        reqV;
      logic        rdy;
      logic        egV;
      logic [79:0] egTs;
      int          reps;
      logic        expValid;
      logic [3:0]  expType;
      logic [15:0] expSeq;
      logic [79:0] expTs;
      logic        expBusy;
   } vec_t;

   vec_t vecs[7];

   // Compare one observed value against a bench-computed expectation.
   task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic checkTx(input string name, input logic v, input logic [3:0] t, input logic [15:0] s,
                          input logic [79:0] p, input logic [79:0] ts);
      checkOutput({name, ".valid"}, 80'(txValid), 80'(v));
      checkOutput({name, ".type"}, 80'(txMsgType), 80'(t));
      checkOutput({name, ".seqid"}, 80'(txSeqid), 80'(s));
      checkOutput({name, ".port"}, txReqPortId, p);
      checkOutput({name, ".ts"}, txTimestamp, ts);
   endtask

   // Drive every input for the coming clock edge.
   task automatic applyStimulus(input logic rv, input logic [15:0] sid, input logic [79:0] pid,
                                input logic [79:0] rts, input logic rdy, input logic ev, input logic [79:0] ets);
      reqValid = rv; reqSeqid = sid; reqPortId = pid; reqRxTs = rts;
      txReady = rdy; egressTsValid = ev; egressTs = ets;
   endtask

   task automatic nextCycle();
      @(negedge clk);
   endtask

   task automatic idleInputs();
      applyStimulus(1'b0, 16'h0, 80'h0, 80'h0, 1'b1, 1'b0, 80'h0);
   endtask

   initial begin
      logic [79:0] portA, portB, portC;
      logic [79:0] expPort;
      int found, pulses;
      logic sawValid, stable;

      portA = 80'h0011223344556677_0001;
      portB = 80'hAABBCCDDEEFF0011_0002;
      portC = 80'h1234567890ABCDEF_0003;

      vecs[0] = '{1'b1, 1'b1, 1'b0, 80'h0,             1, 1'b0, 4'h0, 16'h0,    80'h0,             1'b0};
      vecs[1] = '{1'b0, 1'b1, 1'b1, {48'd5, 32'd777}, 1, 1'b1, 4'h3, 16'h0042, {48'd5, 32'd100}, 1'b1};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 80'h0,             9, 1'b0, 4'h0, 16'h0,    80'h0,             1'b1};
      vecs[3] = '{1'b0, 1'b0, 1'b1, {48'd5, 32'd900}, 1, 1'b0, 4'h0, 16'h0,    80'h0,             1'b1};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 80'h0,             1, 1'b1, 4'hA, 16'h0042, {48'd5, 32'd900}, 1'b1};
      vecs[5] = '{1'b0, 1'b1, 1'b1, {48'd5, 32'd333}, 1, 1'b1, 4'hA, 16'h0042, {48'd5, 32'd900}, 1'b1};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 80'h0,             2, 1'b0, 4'h0, 16'h0,    80'h0,             1'b0};

      // Reset state while reset is held.
      #3;
      checkTx("reset", 1'b0, 4'h0, 16'h0, 80'h0, 80'h0);
      checkOutput("reset.busy", 80'(busy), 80'h0);
      checkOutput("reset.timeout", 80'(tsTimeout), 80'h0);
      checkOutput("reset.drop", 80'(dropCnt), 80'h0);
      @(negedge clk);
      rst = 1'b0;

      // Nominal exchange, one table row per cycle (rows may repeat).
      for (int i = 0; i < 7; i++) begin
         for (int r = 0; r < vecs[i].reps; r++) begin
            nextCycle();
            expPort = vecs[i].expValid ? portA : 80'h0;
            checkTx($sformatf("nom[%0d.%0d]", i, r), vecs[i].expValid, vecs[i].expType,
                    vecs[i].expSeq, expPort, vecs[i].expTs);
            checkOutput($sformatf("nom[%0d.%0d].busy", i, r), 80'(busy), 80'(vecs[i].expBusy));
            checkOutput($sformatf("nom[%0d.%0d].timeout", i, r), 80'(tsTimeout), 80'h0);
            applyStimulus(vecs[i].reqV, 16'h0042, portA, {48'd5, 32'd100},
                          vecs[i].rdy, vecs[i].egV, vecs[i].egTs);
         end
      end

      // Backpressure: Resp held 20 cycles with ready low, then exactly one transfer.
      applyStimulus(1'b1, 16'h0043, portB, {48'd7, 32'd1234}, 1'b0, 1'b0, 80'h0);
      for (int i = 0; i < 20; i++) begin
         nextCycle();
         stable = txValid && txMsgType == 4'h3 && txSeqid == 16'h0043 &&
                  txReqPortId == portB && txTimestamp == {48'd7, 32'd1234};
         checkOutput($sformatf("bp.hold[%0d]", i), 80'(stable), 80'h1);
         applyStimulus(1'b0, 16'h0, 80'h0, 80'h0, 1'b0, 1'b0, 80'h0);
      end
      nextCycle();
      checkTx("bp.last", 1'b1, 4'h3, 16'h0043, portB, {48'd7, 32'd1234});
      applyStimulus(1'b0, 16'h0, 80'h0, 80'h0, 1'b1, 1'b0, 80'h0);
      nextCycle();
      checkOutput("bp.after.valid", 80'(txValid), 80'h0);
      checkOutput("bp.after.busy", 80'(busy), 80'h1);
      applyStimulus(1'b0, 16'h0, 80'h0, 80'h0, 1'b1, 1'b1, {48'd7, 32'd5000});
      nextCycle();
      checkTx("bp.fup", 1'b1, 4'hA, 16'h0043, portB, {48'd7, 32'd5000});
      idleInputs();
      nextCycle();
      checkOutput("bp.idle", 80'(busy), 80'h0);

      // Timeout: no egress timestamp ever arrives.
      applyStimulus(1'b1, 16'h0060, portC, {48'd8, 32'd1}, 1'b1, 1'b0, 80'h0);
      nextCycle();
      checkTx("to.resp", 1'b1, 4'h3, 16'h0060, portC, {48'd8, 32'd1});
      idleInputs();
      found = -1; pulses = 0; sawValid = 1'b0;
      for (int n = 0; n < 130; n++) begin
         nextCycle();
         if (tsTimeout) begin
            pulses++;
            if (found < 0) found = n;
         end
         if (txValid) sawValid = 1'b1;
      end
      checkOutput("to.cycle", 80'(found), 80'(TO_CYC));
      checkOutput("to.pulses", 80'(pulses), 80'h1);
      checkOutput("to.nofup", 80'(sawValid), 80'h0);
      checkOutput("to.idle", 80'(busy), 80'h0);

      // Second request while the first waits for its egress timestamp.
      applyStimulus(1'b1, 16'h0070, portA, {48'd9, 32'd10}, 1'b1, 1'b0, 80'h0);
      nextCycle();
      checkTx("drop.resp", 1'b1, 4'h3, 16'h0070, portA, {48'd9, 32'd10});
      idleInputs();
      nextCycle();
      applyStimulus(1'b1, 16'h0071, portB, {48'd9, 32'd20}, 1'b1, 1'b0, 80'h0);
      nextCycle();
`ifdef PDELAY_RESP_PENDING_BUF_EN
      checkOutput("drop.cnt", 80'(dropCnt), 80'h0);
`else
      checkOutput("drop.cnt", 80'(dropCnt), 80'h1);
`endif
      checkOutput("drop.noresp", 80'(txValid), 80'h0);
      applyStimulus(1'b0, 16'h0, 80'h0, 80'h0, 1'b1, 1'b1, {48'd9, 32'd99});
      nextCycle();
      checkTx("drop.fup", 1'b1, 4'hA, 16'h0070, portA, {48'd9, 32'd99});
      idleInputs();
      nextCycle();
`ifdef PDELAY_RESP_PENDING_BUF_EN
      checkTx("pend.resp", 1'b1, 4'h3, 16'h0071, portB, {48'd9, 32'd20});
      idleInputs();
      nextCycle();
      applyStimulus(1'b0, 16'h0, 80'h0, 80'h0, 1'b1, 1'b1, {48'd9, 32'd55});
      nextCycle();
      checkTx("pend.fup", 1'b1, 4'hA, 16'h0071, portB, {48'd9, 32'd55});
      idleInputs();
      nextCycle();
      checkOutput("pend.cnt", 80'(dropCnt), 80'h0);
`else
      sawValid = 1'b0;
      for (int n = 0; n < 5; n++) begin
         if (txValid || busy) sawValid = 1'b1;
         nextCycle();
      end
      checkOutput("drop.noextra", 80'(sawValid), 80'h0);
`endif
      checkOutput("drop.idle", 80'(busy), 80'h0);

      // Asynchronous reset during WAIT_TS.
      applyStimulus(1'b1, 16'h0080, portC, {48'd1, 32'd0}, 1'b1, 1'b0, 80'h0);
      nextCycle();
      checkTx("rst.resp", 1'b1, 4'h3, 16'h0080, portC, {48'd1, 32'd0});
      idleInputs();
      nextCycle();
      checkOutput("rst.wait", 80'(busy), 80'h1);
      #2 rst = 1'b1;
      #1;
      checkTx("rst.async", 1'b0, 4'h0, 16'h0, 80'h0, 80'h0);
      checkOutput("rst.async.busy", 80'(busy), 80'h0);
      checkOutput("rst.async.timeout", 80'(tsTimeout), 80'h0);
      checkOutput("rst.async.drop", 80'(dropCnt), 80'h0);
      nextCycle();
      rst = 1'b0;
      applyStimulus(1'b0, 16'h0, 80'h0, 80'h0, 1'b1, 1'b1, {48'd1, 32'd1});
      sawValid = 1'b0;
      for (int n = 0; n < 5; n++) begin
         nextCycle();
         if (txValid || busy || tsTimeout) sawValid = 1'b1;
         idleInputs();
      end
      checkOutput("rst.nofup", 80'(sawValid), 80'h0);
      applyStimulus(1'b1, 16'h0081, portA, {48'd2, 32'd2}, 1'b1, 1'b0, 80'h0);
      nextCycle();
      checkTx("rst.next.resp", 1'b1, 4'h3, 16'h0081, portA, {48'd2, 32'd2});
      idleInputs();
      nextCycle();
      applyStimulus(1'b0, 16'h0, 80'h0, 80'h0, 1'b1, 1'b1, {48'd2, 32'd3});
      nextCycle();
      checkTx("rst.next.fup", 1'b1, 4'hA, 16'h0081, portA, {48'd2, 32'd3});
      idleInputs();
      nextCycle();
      checkOutput("rst.next.idle", 80'(busy), 80'h0);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
